// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: TX sequencer states, frame constants, CRC-32 helpers.
package eth_pkg;

  typedef enum logic [1:0] {
    DATA = 2'd0,
    PAD  = 2'd1,
    FCS  = 2'd2
  } tx_fcs_state_t;

  localparam int          ETH_MIN_LEN   = 60;
  localparam int          FCS_LEN       = 4;
  localparam logic [31:0] CRC32_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC32_RESIDUE = 32'h2144df1c;

  // One byte through the reflected CRC-32 register, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/crc32.sv
// Byte-wide reflected CRC-32 engine; crc_o is the final (complemented) FCS value.
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  // Fold the byte in only when enabled, so the value holds across stalls and FCS.
  always_comb begin
    crc_d = crc_q;
    if (en_i) crc_d = crc32_byte(crc_q, data_i);
  end

  // CRC register, restarted from the all-ones seed on reset.
  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC32_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_o = ~crc_q;

endmodule

// File: rtl/eth_tx_fcs.sv
// TX frame sequencer: passes data through, pads short frames, appends the FCS LSB first.
module eth_tx_fcs
  import eth_pkg::*;
#(
  parameter int          MIN_LEN  = ETH_MIN_LEN,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  // A zero minimum still needs a 1-bit counter; it simply never leaves 0.
  localparam int CW = (MIN_LEN > 0) ? $clog2(MIN_LEN + 1) : 1;

  tx_fcs_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   crc;
  logic          xfer;
  logic          frame_end;
  int            cnt_p1;

  assign xfer      = out_valid & out_ready;
  assign cnt_p1    = int'(cnt_q) + 1;
  assign cnt_sat   = (cnt_p1 > MIN_LEN) ? cnt_q : cnt_q + CW'(1);
  assign frame_end = (state_q == FCS) & xfer & (idx_q == 2'(FCS_LEN - 1));

  // Clearing on the last FCS beat lets the next frame's first byte hit a fresh seed.
  crc32 u_crc (
    .clk    (clk),
    .rst    (rst | frame_end),
    .en_i   (xfer & (state_q != FCS)),
    .data_i (out_data),
    .crc_o  (crc)
  );

  // State, byte count and FCS index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DATA;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: everything advances only on an output transfer, so stalls hold all state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (xfer) begin
      case (state_q)
        DATA: begin
          cnt_d = cnt_sat;
          if (in_last) begin
            if (cnt_p1 >= MIN_LEN) begin
              state_d = FCS;
              idx_d   = '0;
            end else begin
              state_d = PAD;
            end
          end
        end
        PAD: begin
          cnt_d = cnt_sat;
          if (cnt_p1 == MIN_LEN) begin
            state_d = FCS;
            idx_d   = '0;
          end
        end
        FCS: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(FCS_LEN - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  // Output mux: combinational pass-through in DATA, generated bytes in PAD/FCS, quiet in reset.
  always_comb begin
    out_data  = in_data;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      DATA: begin
        out_valid = in_valid;
        in_ready  = out_ready;
      end
      PAD: begin
        out_data  = PAD_BYTE;
        out_valid = 1'b1;
      end
      FCS: begin
        out_data  = crc[{idx_q, 3'b000} +: 8];
        out_valid = 1'b1;
        out_last  = (idx_q == 2'(FCS_LEN - 1));
      end
      default: ;
    endcase
    if (rst) begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      in_ready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Bench for eth_tx_fcs: frame-level reference model (pad + CRC + FCS) with a per-cycle compare.
module tb_eth_tx_fcs;
  import eth_pkg::*;

  localparam int ML = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data, out_data;
  logic       in_valid, in_last, in_ready, out_valid, out_last, out_ready;

  logic [7:0] k_in_data, k_out_data;
  logic       k_in_valid, k_in_last, k_in_ready, k_out_valid, k_out_last, k_out_ready;

  eth_tx_fcs dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  eth_tx_fcs #(.MIN_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(k_in_data), .in_valid(k_in_valid), .in_last(k_in_last),
    .in_ready(k_in_ready), .out_data(k_out_data), .out_valid(k_out_valid), .out_last(k_out_last),
    .out_ready(k_out_ready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] last_frame[$];
  int         lens_q[$];
  int         last_out_cyc = 0;
  int         first_acc_cyc = 0;
  bit         rand_ready = 1'b0;
  bit         gaps = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial CRC-32 from its definition: reflected poly, all-ones seed, final complement.
  function automatic logic [31:0] crc_bytes(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = CRC32_INIT;
    foreach (q[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ CRC32_POLY;
      end
    end
    return ~c;
  endfunction

  // Expected wire image of a frame: data, pad to ML, then FCS LSB first with last on byte 3.
  task automatic push_expected(input logic [7:0] d[$]);
    logic [7:0]  p[$];
    logic [31:0] c;
    p = d;
    while (p.size() < ML) p.push_back(8'h00);
    c = crc_bytes(p);
    foreach (p[i]) exp_q.push_back({1'b0, p[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
  endtask

  // Per-cycle compare, sampled well after the falling edge once the driver has settled.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_out_last", {31'h0, out_last}, 32'h0);
      stall_prev = 1'b0;
      frame_q = {};
    end else begin
      if (stall_prev) begin
        chk("stall_data", {24'h0, out_data}, {24'h0, prev_data});
        chk("stall_valid", {31'h0, out_valid}, 32'h1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %h want no byte (cycle %0d)", out_data, cyc);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_data", {24'h0, out_data}, {24'h0, e[7:0]});
          chk("out_last", {31'h0, out_last}, {31'h0, e[8]});
        end
        frame_q.push_back(out_data);
        if (out_last) begin
          chk("residue", crc_bytes(frame_q), CRC32_RESIDUE);
          lens_q.push_back(frame_q.size());
          last_frame = frame_q;
          frame_q = {};
          last_out_cyc = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      bit acc;
      int g;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      acc = 1'b0;
      g = 0;
      while (!acc) begin
        @(negedge clk);
        tick();
        in_valid = 1'b1;
        in_data  = d[i];
        in_last  = (i == d.size() - 1);
        #1;
        acc = in_ready;
        if (acc && i == 0) first_acc_cyc = cyc;
        g++;
        if (g > 1000) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: got no in_ready want accept of byte %0d", i);
          return;
        end
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      g++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d bytes left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_len(input int n);
    if (lens_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL frame_len: got no frame want %0d bytes", (n < ML ? ML : n) + 4);
    end else begin
      chk("frame_len", lens_q.pop_front(), (n < ML ? ML : n) + 4);
    end
  endtask

  task automatic run_frame(input logic [7:0] d[$]);
    push_expected(d);
    send(d);
    drain();
    check_len(d.size());
  endtask

  function automatic void rnd_frame(output logic [7:0] d[$], input int n);
    d = {};
    for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end

  initial begin
    logic [7:0] kat[9];
    logic [7:0] kf[4];
    logic [7:0] f[$];
    logic [7:0] f2[$];
    logic [7:0] ref70[$];
    int         diffs;
    int         g;

    kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    kf  = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    k_in_valid = 1'b0; k_in_last = 1'b0; k_in_data = 8'h00; k_out_ready = 1'b1;

    // Pin the model itself to the published check value.
    f = {};
    foreach (kat[i]) f.push_back(kat[i]);
    chk("model_kat", crc_bytes(f), 32'hCBF43926);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_k_out_valid", {31'h0, k_out_valid}, 32'h0);
    chk("rst_k_in_ready", {31'h0, k_in_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_out_valid", {31'h0, out_valid}, 32'h0);

    // Known-answer on the unpadded instance: pass-through then 26 39 F4 CB.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      k_in_valid = 1'b1; k_in_data = kat[i]; k_in_last = (i == 8);
      #1;
      chk("kat_data", {24'h0, k_out_data}, {24'h0, kat[i]});
      chk("kat_in_ready", {31'h0, k_in_ready}, 32'h1);
      chk("kat_last_data", {31'h0, k_out_last}, 32'h0);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      k_in_valid = 1'b0; k_in_last = 1'b0;
      #1;
      chk("kat_fcs", {24'h0, k_out_data}, {24'h0, kf[j]});
      chk("kat_fcs_valid", {31'h0, k_out_valid}, 32'h1);
      chk("kat_fcs_last", {31'h0, k_out_last}, {31'h0, (j == 3)});
    end
    @(negedge clk);
    #1;
    chk("kat_after_valid", {31'h0, k_out_valid}, 32'h0);

    // Short frame padded to 60 bytes.
    f = {};
    for (int i = 1; i <= 10; i++) f.push_back(8'(i));
    run_frame(f);
    if (last_frame.size() == 64) begin
      chk("pad_last_data", {24'h0, last_frame[9]}, 32'h0A);
      chk("pad_first", {24'h0, last_frame[10]}, 32'h00);
      chk("pad_final", {24'h0, last_frame[59]}, 32'h00);
    end

    // Back-to-back 64-byte frames, in_valid held high throughout.
    rnd_frame(f, 64);
    rnd_frame(f2, 64);
    push_expected(f);
    send(f);
    push_expected(f2);
    send(f2);
    chk("b2b_gap", first_acc_cyc - last_out_cyc, 1);
    drain();
    check_len(64);
    check_len(64);

    // 70-byte frame without stalls, then the same frame under random backpressure.
    rnd_frame(f, 70);
    run_frame(f);
    ref70 = last_frame;
    rand_ready = 1'b1;
    gaps = 1'b1;
    run_frame(f);
    rand_ready = 1'b0;
    gaps = 1'b0;
    diffs = 0;
    if (last_frame.size() != ref70.size()) diffs = 1000;
    else foreach (ref70[i]) if (ref70[i] !== last_frame[i]) diffs++;
    chk("stall_vs_nostall", diffs, 0);

    // Reset in the middle of the FCS, then a fresh 60-byte frame.
    rnd_frame(f, 60);
    push_expected(f);
    send(f);
    g = 0;
    while (exp_q.size() != 3 && g < 500) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      #3;
      g++;
    end
    chk("reach_fcs_idx1", exp_q.size(), 3);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_idle", {31'h0, out_valid}, 32'h0);
    chk("rst_no_frame", lens_q.size(), 0);
    rnd_frame(f, 60);
    run_frame(f);

    // Exact boundary: one pad byte, then none.
    rnd_frame(f, 59);
    run_frame(f);
    if (last_frame.size() == 64)
      chk("boundary_pad", {24'h0, last_frame[59]}, 32'h00);
    rnd_frame(f, 60);
    run_frame(f);

    // Random lengths with random backpressure and idle gaps.
    rand_ready = 1'b1;
    gaps = 1'b1;
    for (int r = 0; r < 8; r++) begin
      rnd_frame(f, $urandom_range(1, 80));
      run_frame(f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_fcs.md
# eth_tx_fcs

Transmit-side frame sequencer for the Ethernet MAC. It passes a byte stream from the TX frame source to the PHY-side byte interface and feeds each byte into a `crc32` engine. Short frames are padded to the minimum length. After each frame it appends the 4-byte FCS, least significant byte first. It is the only owner of the CRC engine's enable and clear inputs.

## Interface
Parameters:
- `MIN_LEN`, default 60: minimum bytes before the FCS (data plus pad). `0` disables padding.
- `PAD_BYTE`, default 8'h00: value emitted for pad bytes.

Ports:
- `clk`, input, 1: single clock. Every register in the block is clocked on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_data`, input, 8: frame byte from the source.
- `in_valid`, input, 1: `in_data` is valid.
- `in_last`, input, 1: the current input byte is the last data byte of the frame.
- `in_ready`, output, 1: the block accepts the input byte this cycle.
- `out_data`, output, 8: byte to the PHY side.
- `out_valid`, output, 1: `out_data` is valid.
- `out_last`, output, 1: the current output byte is the final FCS byte.
- `out_ready`, output-side input, 1: the downstream consumer accepts the output byte.

## Operation
- **Transfers.**
  - Output transfer (`xfer`): `out_valid & out_ready` in the same cycle.
  - Input transfer: `in_valid & in_ready`.
- **States:** `DATA` (reset state), `PAD`, `FCS`.
- **Registers:**
  - `cnt` counts bytes of the current frame. It is `$clog2(MIN_LEN+1)` bits wide, increments on each DATA or PAD `xfer`, and saturates at `MIN_LEN`.
  - `idx` is the 2-bit FCS byte index.
- **DATA:**
  - Combinational pass-through: `out_data=in_data`, `out_valid=in_valid`, `in_ready=out_ready`, `out_last=0`.
  - On `xfer` with `in_last=1`:
    - if `cnt+1 >= MIN_LEN`, go to FCS with `idx=0`;
    - otherwise go to PAD.
- **PAD:**
  - `out_data=PAD_BYTE`, `out_valid=1`, `in_ready=0`.
  - On `xfer`, when `cnt+1 == MIN_LEN`, go to FCS with `idx=0`.
- **FCS:**
  - `out_data = crc[8*idx +: 8]`, `out_valid=1`, `in_ready=0`.
  - `out_last = (idx==3)`.
  - On `xfer`, `idx` increments.
  - On `xfer` with `idx==3`, go to DATA and clear `cnt`.
- **CRC engine control:**
  - `en = xfer & (state != FCS)`, so data and pad bytes are both covered by the CRC.
  - `data_in = out_data`.
  - Engine reset = `rst | (state==FCS & xfer & idx==3)`. This clears the engine on the same edge the frame ends, so there is no gap before the next frame.
  - The CRC value is stable throughout FCS because `en` is low there.
- **Frame boundary:** the first byte of a new frame is accepted in the cycle right after the last FCS `xfer`.
- **Reset:**
  - `rst` mid-frame discards the partial frame. No FCS is emitted.
  - Reset returns to DATA, `cnt=0`, `idx=0`, CRC state `ffffffff`.
  - While `rst=1`: `in_ready=0`, `out_valid=0`, `out_last=0`. `out_data` is don't-care.
- **Length rule:** `in_last` on a byte beyond `MIN_LEN` is legal; the count stays saturated. There is no maximum-length check.

## Timing
- DATA has zero latency: input and output are combinationally coupled.
- There are no registered outputs other than the state-driven ones.
- Cycle count with `out_ready` held high:
  - a frame of N ≥ `MIN_LEN` bytes takes N+4 output cycles;
  - a frame of N < `MIN_LEN` bytes takes `MIN_LEN`+4 output cycles.
- `out_ready` low stalls every state. While stalled, `out_data`, `out_valid`, `state`, `cnt`, `idx` and the CRC value are all held.
- `in_valid` low in DATA inserts idle cycles with no state change.

## Structure
- Shared package `eth_pkg`:
  - state enum `tx_fcs_state_t {DATA, PAD, FCS}`;
  - `ETH_MIN_LEN = 60`, `FCS_LEN = 4`;
  - `CRC32_POLY = 32'hedb88320`, `CRC32_INIT = 32'hffffffff`, `CRC32_RESIDUE = 32'h2144df1c` (residue after the final XOR).
- One sub-module: the existing `crc32` engine, instantiated once as `u_crc`.
- Everything else (the FSM, `cnt`, `idx`, and the output muxing) is flat in `eth_tx_fcs`.

## Test plan
- **Known-answer CRC.** Setup: `MIN_LEN=0`, ASCII "123456789", `in_last` on '9', `out_ready=1`. Required: the 9 bytes pass through unchanged, then 26 39 F4 CB, with `out_last` on CB only.
- **Pad.** Setup: default `MIN_LEN`, 10-byte frame 01..0A. Required: 10 data bytes, 50×00, 4 FCS bytes, 64 output bytes in total. The bench CRC over all 64 bytes must equal `CRC32_RESIDUE`.
- **Back-to-back frames.** Setup: two 64-byte frames, `in_valid` held high. Required: no pad on either frame; the second frame's first byte is accepted the cycle after the first frame's `out_last`; both FCS values match the reference model.
- **Random backpressure.** Setup: 70-byte frame, `out_ready` toggling randomly at 50%. Required: output byte sequence identical to the no-stall run; `out_data` stable during every stall cycle.
- **Reset mid-FCS.** Setup: assert `rst` at `idx=1`, then send a 60-byte frame. Required: no further bytes of the old FCS; `out_valid=0` during reset; the new frame's FCS is correct (engine restarted from `ffffffff`).
- **Exact boundary.** Setup: 59-byte frame, then a 60-byte frame. Required: exactly 1 pad byte for the first frame, 0 for the second, and both FCS values correct.
